instruction_loader: RTL and testbench

//  Write-side master for the MAC engine instruction memory. Accepts a stream of
//  32-bit instruction fields over a valid/ready port. Packs each group of
//  NUM_FIELDS words into one instruction slot, and drives the memory's external

---
 rtl/instruction_loader_pkg.sv | 25 ++
 rtl/instruction_loader_field_counter.sv | 28 ++
 rtl/instruction_loader.sv | 132 +++++++++++++
 tb/tb_instruction_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and instruction memory:
// FSM states, geometry constants and the {slot, field} address packing.
package instruction_loader_pkg;

  localparam int NUM_FIELDS  = 8;
  localparam int FIELD_WIDTH = 32;
  localparam int IM_SIZE     = 2;
  localparam int FIELD_BITS  = 3;
  localparam int ADDR_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  // Slot number occupies the upper address bits, field index the low bits.
  function automatic logic [ADDR_W-1:0] pack_im_addr(
    input logic [ADDR_W-1:0]     slot,
    input logic [FIELD_BITS-1:0] field
  );
    return {slot[ADDR_W-1-FIELD_BITS:0], field};
  endfunction

endpackage

// File: rtl/instruction_loader_field_counter.sv
// Field index counter: counts 0..NUM_FIELDS-1 and flags the wrap so the
// parent can advance its instruction count on the same handshake.
module field_counter #(
  parameter int NUM_FIELDS = 8,
  parameter int FIELD_BITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_inc,
  output logic [FIELD_BITS-1:0] o_cnt,
  output logic                  o_wrap
);

  localparam logic [FIELD_BITS-1:0] LAST = FIELD_BITS'(NUM_FIELDS - 1);

  logic [FIELD_BITS-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_wrap = i_inc && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/instruction_loader.sv
// Stream-to-instruction-memory write master: packs NUM_FIELDS stream words per
// slot and drives the memory's external write port with a 1-cycle latency.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int NUM_FIELDS  = instruction_loader_pkg::NUM_FIELDS,
  parameter int FIELD_WIDTH = instruction_loader_pkg::FIELD_WIDTH,
  parameter int IM_SIZE     = instruction_loader_pkg::IM_SIZE,
  parameter int FIELD_BITS  = instruction_loader_pkg::FIELD_BITS
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [31:0]            i_base_instr,
  input  logic [31:0]            i_num_instr,
  input  logic                   i_in_valid,
  input  logic [FIELD_WIDTH-1:0] i_in_data,
  output logic                   o_in_ready,
  output logic [31:0]            o_wr_addr_ext_im,
  output logic [FIELD_WIDTH-1:0] o_wr_data_ext_im,
  output logic                   o_wr_en_ext_im,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error
);

  ld_state_e r_state, w_state_nxt;

  logic [31:0]            r_base, r_num, r_instr_cnt;
  logic [31:0]            r_wr_addr;
  logic [FIELD_WIDTH-1:0] r_wr_data;
  logic                   r_wr_en, r_error;

  logic                  w_hs, w_wrap, w_last;
  logic                  w_accept, w_reject, w_empty;
  logic                  w_oor;
  logic [32:0]           w_sum;
  logic [FIELD_BITS-1:0] w_field;
  logic [31:0]           w_slot;

  // Sum taken one bit wider so a 32-bit overflow lands out of range.
  assign w_sum = {1'b0, i_base_instr} + {1'b0, i_num_instr};
  assign w_oor = w_sum > 33'(IM_SIZE);

  assign o_in_ready = (r_state == ST_LOAD);
  assign o_busy     = (r_state == ST_LOAD);
  assign o_done     = (r_state == ST_DONE);
  assign o_error    = r_error;

  assign o_wr_addr_ext_im = r_wr_addr;
  assign o_wr_data_ext_im = r_wr_data;
  assign o_wr_en_ext_im   = r_wr_en;

  assign w_hs   = i_in_valid && o_in_ready;
  assign w_last = w_wrap && (r_instr_cnt == r_num - 32'd1);
  assign w_slot = r_base + r_instr_cnt;

  field_counter #(
    .NUM_FIELDS (NUM_FIELDS),
    .FIELD_BITS (FIELD_BITS)
  ) u_field_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_accept),
    .i_inc   (w_hs),
    .o_cnt   (w_field),
    .o_wrap  (w_wrap)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_empty     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_num_instr == 32'd0) begin
            w_empty     = 1'b1;
            w_state_nxt = ST_DONE;
          end else if (w_oor) begin
            w_reject    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_num       <= '0;
      r_instr_cnt <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_base      <= i_base_instr;
        r_num       <= i_num_instr;
        r_instr_cnt <= '0;
      end else if (w_wrap) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
      if (w_reject)                r_error <= 1'b1;
      else if (w_accept | w_empty) r_error <= 1'b0;
    end
  end

  // Write port is registered; address and data hold between writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_hs;
      if (w_hs) begin
        r_wr_addr <= {w_slot[31-FIELD_BITS:0], w_field};
        r_wr_data <= i_in_data;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader with a behavioural write model.
module tb_instruction_loader;

  localparam int NF = 8;

  logic        clk, rst_n, start, in_valid;
  logic [31:0] base_instr, num_instr, in_data;
  logic        in_ready, wr_en, busy, done, error;
  logic [31:0] wr_addr, wr_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] mem     [16];
  logic [31:0] exp_mem [16];

  instruction_loader dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_base_instr     (base_instr),
    .i_num_instr      (num_instr),
    .i_in_valid       (in_valid),
    .i_in_data        (in_data),
    .o_in_ready       (in_ready),
    .o_wr_addr_ext_im (wr_addr),
    .o_wr_data_ext_im (wr_data),
    .o_wr_en_ext_im   (wr_en),
    .o_busy           (busy),
    .o_done           (done),
    .o_error          (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for instruction_memory's external write port.
  always @(negedge clk)
    if (rst_n && wr_en && wr_addr < 32'd16) mem[wr_addr[3:0]] <= wr_data;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    base_instr = '0; num_instr = '0;
    #1;
    total_cnt++;
    if ({wr_en, busy, done, error, in_ready} !== 5'b0 || wr_addr !== 32'd0 || wr_data !== 32'd0)
      $display("FAIL reset_init: got en%b bsy%b dn%b er%b rdy%b a%h d%h want all 0",
               wr_en, busy, done, error, in_ready, wr_addr, wr_data);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    start = 1'b1; base_instr = 32'd0; num_instr = 32'd1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    @(negedge clk); in_data = 32'h22;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({wr_en, busy, done, error, in_ready} !== 5'b0 || wr_addr !== 32'd0 || wr_data !== 32'd0)
      $display("FAIL reset_mid: got en%b bsy%b dn%b er%b rdy%b a%h d%h want all 0",
               wr_en, busy, done, error, in_ready, wr_addr, wr_data);
    else pass_cnt++;
    in_valid = 1'b0;
    exp_mem[0] = 32'h11; exp_mem[1] = 32'h22;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_release: got rdy%b bsy%b dn%b want 0 0 0", in_ready, busy, done);
    else pass_cnt++;
  endtask

  // Runs one accepted load from IDLE. vmode: 0 full rate, 1 toggle, 2 random.
  task automatic stream_load(input logic [31:0] base, input logic [31:0] num,
                             input int vmode, input bit fixed, input bit poke,
                             input string tag);
    int total, acc, cyc;
    bit prev_hs;
    logic [31:0] e_addr, e_data;
    total = int'(num) * NF; acc = 0; cyc = 0; prev_hs = 1'b0;
    e_addr = '0; e_data = '0;
    start = 1'b1; base_instr = base; num_instr = num; in_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    while (acc < total && cyc < 4000) begin
      total_cnt++;
      if (wr_en !== prev_hs)
        $display("FAIL %s wr_en cyc%0d: got %b want %b", tag, cyc, wr_en, prev_hs);
      else pass_cnt++;
      if (prev_hs) begin
        total_cnt++;
        if (wr_addr !== e_addr || wr_data !== e_data)
          $display("FAIL %s write cyc%0d: got a%h d%h want a%h d%h", tag, cyc, wr_addr, wr_data, e_addr, e_data);
        else pass_cnt++;
      end
      total_cnt++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0)
        $display("FAIL %s load_flags cyc%0d: got bsy%b rdy%b dn%b want 1 1 0", tag, cyc, busy, in_ready, done);
      else pass_cnt++;
      start = 1'b0;
      if (poke && cyc == 3) begin
        start = 1'b1; base_instr = 32'd0; num_instr = 32'd1;
      end
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(99) < 60);
      endcase
      in_data = fixed ? 32'hA0 + 32'(acc) : $urandom;
      if (in_valid) begin
        e_addr = (base + 32'(acc / NF)) * NF + 32'(acc % NF);
        e_data = in_data;
        exp_mem[e_addr[3:0]] = e_data;
        acc++;
      end
      prev_hs = in_valid;
      @(negedge clk); cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (acc < total) $display("FAIL %s timeout: got %0d words want %0d", tag, acc, total);
    else pass_cnt++;
    total_cnt++;
    if (wr_en !== 1'b1 || wr_addr !== e_addr || wr_data !== e_data)
      $display("FAIL %s last_write: got en%b a%h d%h want 1 a%h d%h", tag, wr_en, wr_addr, wr_data, e_addr, e_data);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL %s done_cycle: got dn%b bsy%b rdy%b want 1 0 0", tag, done, busy, in_ready);
    else pass_cnt++;
    // Offer an extra word and a start during DONE: both must be ignored.
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    start = 1'b1; base_instr = 32'd0; num_instr = 32'd1;
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL %s after_done: got en%b dn%b bsy%b rdy%b want 0 0 0 0", tag, wr_en, done, busy, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_full_rate();
    stream_load(32'd0, 32'd2, 0, 1'b1, 1'b0, "full_rate");
    @(negedge clk);
    total_cnt++;
    if (mem[15] !== 32'hAF) $display("FAIL full_rate mem_pc1_f7: got %h want 000000af", mem[15]);
    else pass_cnt++;
    total_cnt++;
    if (mem[0] !== 32'hA0) $display("FAIL full_rate mem_pc0_f0: got %h want 000000a0", mem[0]);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    stream_load(32'd1, 32'd1, 1, 1'b0, 1'b0, "toggle");
    stream_load(32'd0, 32'd2, 2, 1'b0, 1'b0, "random");
  endtask

  task automatic reject_case(input logic [31:0] base, input logic [31:0] num,
                             input bit exp_err, input string tag);
    start = 1'b1; base_instr = base; num_instr = num;
    @(negedge clk); start = 1'b0;
    total_cnt++;
    if (done !== 1'b1 || error !== exp_err || busy !== 1'b0 || in_ready !== 1'b0 || wr_en !== 1'b0)
      $display("FAIL %s pulse: got dn%b er%b bsy%b rdy%b en%b want 1 %b 0 0 0",
               tag, done, error, busy, in_ready, wr_en, exp_err);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || error !== exp_err || in_ready !== 1'b0 || wr_en !== 1'b0)
      $display("FAIL %s after: got dn%b er%b rdy%b en%b want 0 %b 0 0", tag, done, error, in_ready, wr_en, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_reject();
    reject_case(32'd1, 32'd2, 1'b1, "rej_range");
    reject_case(32'hFFFF_FFFF, 32'd2, 1'b1, "rej_wrap");
    reject_case(32'd2, 32'd1, 1'b1, "rej_edge");
    stream_load(32'd0, 32'd1, 2, 1'b0, 1'b0, "rej_clear");
    total_cnt++;
    if (error !== 1'b0) $display("FAIL rej_clear error: got %b want 0", error);
    else pass_cnt++;
  endtask

  task automatic test_zero_and_poke();
    reject_case(32'd5, 32'd0, 1'b0, "zero_num");
    stream_load(32'd1, 32'd1, 0, 1'b0, 1'b1, "start_in_load");
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1; base_instr = 32'd0; num_instr = 32'd2;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 32'h50 + 32'(k);
      exp_mem[k] = 32'h50 + 32'(k);
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = 32'h55;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({wr_en, busy, done, in_ready} !== 4'b0 || wr_addr !== 32'd0)
      $display("FAIL abort_outputs: got en%b bsy%b dn%b rdy%b a%h want all 0", wr_en, busy, done, in_ready, wr_addr);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_no_done: got dn%b bsy%b want 0 0", done, busy);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      total_cnt++;
      if (mem[k] !== exp_mem[k]) $display("FAIL abort_mem[%0d]: got %h want %h", k, mem[k], exp_mem[k]);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0; exp_mem[i] = '0;
    end
    test_reset();
    test_full_rate();
    test_gaps();
    test_reject();
    test_zero_and_poke();
    test_reset_mid_load();
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (mem[i] !== exp_mem[i]) $display("FAIL final_mem[%0d]: got %h want %h", i, mem[i], exp_mem[i]);
      else pass_cnt++;
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
